uart_cmd_parser: RTL and testbench

Packet-level controller for the UART receive path. It consumes the byte stream from uart_rx (i_Rx_DV/i_Rx_Byte), frames and validates command packets, buffers the write payload, and replays it as single-cycle register writes only after the checksum passes. Read commands become a single request pulse to the register block. It sits between uart_rx and the board register file on the 50 MHz clock.

---
 rtl/uart_cmd_pkg.sv | 31 +++
 rtl/uart_cmd_if.sv | 34 +++
 rtl/uart_cmd_buf.sv | 22 ++
 rtl/uart_cmd_parser.sv | 200 ++++++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: opcodes, error codes and FSM states
// shared by the UART command parser files.
package uart_cmd_pkg;

  localparam logic [7:0] SOF_DEF = 8'hA5;
  localparam logic [7:0] CMD_WR  = 8'h01;
  localparam logic [7:0] CMD_RD  = 8'h02;

  localparam logic [1:0] ERR_FMT  = 2'd0;
  localparam logic [1:0] ERR_CSUM = 2'd1;
  localparam logic [1:0] ERR_TMO  = 2'd2;
  localparam logic [1:0] ERR_OVR  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_LEN,
    ST_DATA,
    ST_CSUM,
    ST_COMMIT,
    ST_RDREQ
  } state_t;

  function automatic logic [7:0] sat_inc(
    input logic [7:0] v
  );
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_cmd_if.sv
// uart_cmd_if: rx byte stream in, register bus out.
// master = parser side, slave = uart_rx/register side.
interface uart_cmd_if;

  logic       i_Rx_DV;
  logic [7:0] i_Rx_Byte;
  logic       o_Wr_En;
  logic [7:0] o_Wr_Addr;
  logic [7:0] o_Wr_Data;
  logic       o_Rd_Req;
  logic [7:0] o_Rd_Addr;
  logic [7:0] o_Rd_Len;
  logic       o_Busy;
  logic       o_Err;
  logic [1:0] o_Err_Code;
  logic [7:0] o_Err_Cnt;

  modport master (
    input  i_Rx_DV, i_Rx_Byte,
    output o_Wr_En, o_Wr_Addr, o_Wr_Data,
    output o_Rd_Req, o_Rd_Addr, o_Rd_Len,
    output o_Busy, o_Err, o_Err_Code,
    output o_Err_Cnt
  );

  modport slave (
    output i_Rx_DV, i_Rx_Byte,
    input  o_Wr_En, o_Wr_Addr, o_Wr_Data,
    input  o_Rd_Req, o_Rd_Addr, o_Rd_Len,
    input  o_Busy, o_Err, o_Err_Code,
    input  o_Err_Cnt
  );

endinterface

// File: rtl/uart_cmd_buf.sv
// uart_cmd_buf: write-payload store, one write port,
// one combinational read port; contents not reset.
module uart_cmd_buf #(
  parameter int AW = 3
) (
  input  logic          i_Clock,
  input  logic          i_We,
  input  logic [AW-1:0] i_Wr_Idx,
  input  logic [7:0]    i_Wr_Data,
  input  logic [AW-1:0] i_Rd_Idx,
  output logic [7:0]    o_Rd_Data
);

  logic [7:0] r_mem [2**AW];

  always_ff @(posedge i_Clock) begin
    if (i_We) r_mem[i_Wr_Idx] <= i_Wr_Data;
  end

  assign o_Rd_Data = r_mem[i_Rd_Idx];

endmodule

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: frames SOF/CMD/ADDR/LEN/data/CSUM packets,
// replays writes after checksum, issues read requests.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int         MAX_LEN      = 8,
  parameter int         TIMEOUT_CLKS = 50000,
  parameter logic [7:0] SOF_BYTE     = SOF_DEF
) (
  input logic      i_Clock,
  input logic      i_Rst_n,
  uart_cmd_if.master bus
);

  localparam int IW = $clog2(MAX_LEN + 1);
  localparam int AW =
    (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW =
    (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [TW-1:0] TMO_LAST =
    TW'(TIMEOUT_CLKS - 1);
  localparam logic [7:0] LEN_MAX = 8'(MAX_LEN);

  state_t        r_state;
  logic [7:0]    r_cmd, r_addr, r_len, r_csum;
  logic [IW-1:0] r_idx;
  logic [TW-1:0] r_tmo;

  logic       r_Wr_En, r_Rd_Req, r_Err;
  logic [7:0] r_Wr_Addr, r_Wr_Data;
  logic [7:0] r_Rd_Addr, r_Rd_Len, r_Err_Cnt;
  logic [1:0] r_Err_Code;

  logic          w_dv;
  logic [7:0]    w_byte, w_rd_data;
  logic [IW-1:0] w_idx_nx;
  logic [AW-1:0] w_rd_idx;
  logic          w_in_pkt;

  assign w_dv     = bus.i_Rx_DV;
  assign w_byte   = bus.i_Rx_Byte;
  assign w_idx_nx = r_idx + IW'(1);
  assign w_in_pkt = (r_state == ST_CMD)  ||
                    (r_state == ST_ADDR) ||
                    (r_state == ST_LEN)  ||
                    (r_state == ST_DATA) ||
                    (r_state == ST_CSUM);
  // CSUM reads slot 0 for the first write
  assign w_rd_idx = (r_state == ST_COMMIT) ?
                    r_idx[AW-1:0] : '0;

  uart_cmd_buf #(.AW(AW)) u_buf (
    .i_Clock   (i_Clock),
    .i_We      (r_state == ST_DATA && w_dv),
    .i_Wr_Idx  (r_idx[AW-1:0]),
    .i_Wr_Data (w_byte),
    .i_Rd_Idx  (w_rd_idx),
    .o_Rd_Data (w_rd_data)
  );

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_state    <= ST_IDLE;
      r_cmd      <= '0;
      r_addr     <= '0;
      r_len      <= '0;
      r_csum     <= '0;
      r_idx      <= '0;
      r_tmo      <= '0;
      r_Wr_En    <= 1'b0;
      r_Wr_Addr  <= '0;
      r_Wr_Data  <= '0;
      r_Rd_Req   <= 1'b0;
      r_Rd_Addr  <= '0;
      r_Rd_Len   <= '0;
      r_Err      <= 1'b0;
      r_Err_Code <= '0;
      r_Err_Cnt  <= '0;
    end else begin
      r_Wr_En  <= 1'b0;
      r_Rd_Req <= 1'b0;
      r_Err    <= 1'b0;
      if (w_in_pkt)
        r_tmo <= w_dv ? '0 : r_tmo + TW'(1);
      unique case (r_state)
        ST_IDLE: begin
          if (w_dv && w_byte == SOF_BYTE) begin
            r_state <= ST_CMD;
            r_csum  <= '0;
            r_idx   <= '0;
            r_tmo   <= '0;
          end
        end
        ST_CMD: begin
          if (w_dv) begin
            r_cmd   <= w_byte;
            r_csum  <= r_csum ^ w_byte;
            r_state <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (w_dv) begin
            r_addr  <= w_byte;
            r_csum  <= r_csum ^ w_byte;
            r_state <= ST_LEN;
          end
        end
        ST_LEN: begin
          if (w_dv) begin
            r_len  <= w_byte;
            r_csum <= r_csum ^ w_byte;
            if (r_cmd == CMD_WR && w_byte != 8'd0 &&
                w_byte <= LEN_MAX)
              r_state <= ST_DATA;
            else if (r_cmd == CMD_RD && w_byte != 8'd0)
              r_state <= ST_CSUM;
            else begin
              r_state    <= ST_IDLE;
              r_Err      <= 1'b1;
              r_Err_Code <= ERR_FMT;
              r_Err_Cnt  <= sat_inc(r_Err_Cnt);
            end
          end
        end
        ST_DATA: begin
          if (w_dv) begin
            r_csum <= r_csum ^ w_byte;
            r_idx  <= w_idx_nx;
            if (w_idx_nx == r_len[IW-1:0])
              r_state <= ST_CSUM;
          end
        end
        ST_CSUM: begin
          if (w_dv) begin
            if (w_byte != r_csum) begin
              r_state    <= ST_IDLE;
              r_Err      <= 1'b1;
              r_Err_Code <= ERR_CSUM;
              r_Err_Cnt  <= sat_inc(r_Err_Cnt);
            end else if (r_cmd == CMD_WR) begin
              r_state   <= ST_COMMIT;
              r_Wr_En   <= 1'b1;
              r_Wr_Addr <= r_addr;
              r_Wr_Data <= w_rd_data;
              r_idx     <= IW'(1);
            end else begin
              r_state   <= ST_RDREQ;
              r_Rd_Req  <= 1'b1;
              r_Rd_Addr <= r_addr;
              r_Rd_Len  <= r_len;
            end
          end
        end
        ST_COMMIT: begin
          // r_idx counts strobes already issued
          if (r_idx == r_len[IW-1:0])
            r_state <= ST_IDLE;
          else begin
            r_Wr_En   <= 1'b1;
            r_Wr_Addr <= r_addr + 8'(r_idx);
            r_Wr_Data <= w_rd_data;
            r_idx     <= w_idx_nx;
          end
          if (w_dv) begin
            r_Err      <= 1'b1;
            r_Err_Code <= ERR_OVR;
            r_Err_Cnt  <= sat_inc(r_Err_Cnt);
          end
        end
        ST_RDREQ: begin
          r_state <= ST_IDLE;
          if (w_dv) begin
            r_Err      <= 1'b1;
            r_Err_Code <= ERR_OVR;
            r_Err_Cnt  <= sat_inc(r_Err_Cnt);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      if (w_in_pkt && !w_dv && r_tmo == TMO_LAST) begin
        r_state    <= ST_IDLE;
        r_Err      <= 1'b1;
        r_Err_Code <= ERR_TMO;
        r_Err_Cnt  <= sat_inc(r_Err_Cnt);
      end
    end
  end

  assign bus.o_Wr_En    = r_Wr_En;
  assign bus.o_Wr_Addr  = r_Wr_Addr;
  assign bus.o_Wr_Data  = r_Wr_Data;
  assign bus.o_Rd_Req   = r_Rd_Req;
  assign bus.o_Rd_Addr  = r_Rd_Addr;
  assign bus.o_Rd_Len   = r_Rd_Len;
  assign bus.o_Busy     = (r_state != ST_IDLE);
  assign bus.o_Err      = r_Err;
  assign bus.o_Err_Code = r_Err_Code;
  assign bus.o_Err_Cnt  = r_Err_Cnt;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: packet-level model + per-cycle
// compare, plus literal checks on logged bus traffic.
module tb_uart_cmd_parser;
  import uart_cmd_pkg::*;

  localparam int T    = 50000;
  localparam int MAXL = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #10 clk = ~clk;

  uart_cmd_if bus();

  uart_cmd_parser #(
    .MAX_LEN      (MAXL),
    .TIMEOUT_CLKS (T),
    .SOF_BYTE     (8'hA5)
  ) dut (
    .i_Clock (clk),
    .i_Rst_n (rst_n),
    .bus     (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  // ---------------- packet-level model
  bit         m_in   = 0;
  logic [7:0] m_q[$];
  int         m_idle = 0;
  int         m_busy = 0;
  logic [15:0] m_wq[$];

  logic       e_wr = 0, e_rd = 0, e_busy = 0, e_err = 0;
  logic [7:0] e_wa = 0, e_wd = 0, e_ra = 0, e_rl = 0;
  logic [1:0] e_code = 0;
  logic [7:0] e_cnt = 0;

  task automatic m_err(input logic [1:0] c);
    e_err  = 1'b1;
    e_code = c;
    if (e_cnt != 8'hFF) e_cnt++;
  endtask

  task automatic m_eval();
    int n;
    int need;
    logic [7:0] cmd, len, x, a;
    logic [15:0] w;
    n = m_q.size();
    if (n < 3) return;
    cmd = m_q[0];
    len = m_q[2];
    if (n == 3) begin
      if (!((cmd == 8'h01 && len >= 1 && len <= MAXL) ||
            (cmd == 8'h02 && len >= 1))) begin
        m_err(ERR_FMT);
        m_in = 0;
      end
      return;
    end
    need = (cmd == 8'h01) ? 4 + int'(len) : 4;
    if (n != need) return;
    m_in = 0;
    x = 8'h00;
    for (int i = 0; i < n - 1; i++) x ^= m_q[i];
    if (x != m_q[n-1]) begin
      m_err(ERR_CSUM);
    end else if (cmd == 8'h01) begin
      for (int i = 0; i < int'(len); i++) begin
        a = m_q[1] + 8'(i);
        m_wq.push_back({a, m_q[3+i]});
      end
      w    = m_wq.pop_front();
      e_wr = 1'b1;
      e_wa = w[15:8];
      e_wd = w[7:0];
      m_busy = int'(len);
    end else begin
      e_rd = 1'b1;
      e_ra = m_q[1];
      e_rl = len;
      m_busy = 1;
    end
  endtask

  initial begin
    logic [15:0] w;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_in = 0; m_idle = 0; m_busy = 0;
        m_q.delete(); m_wq.delete();
        e_wr = 0; e_rd = 0; e_busy = 0; e_err = 0;
        e_wa = 0; e_wd = 0; e_ra = 0; e_rl = 0;
        e_code = 0; e_cnt = 0;
      end else begin
        e_wr = 0; e_rd = 0; e_err = 0;
        if (m_busy > 0) begin
          if (bus.i_Rx_DV) m_err(ERR_OVR);
          m_busy--;
          if (m_wq.size() > 0) begin
            w    = m_wq.pop_front();
            e_wr = 1'b1;
            e_wa = w[15:8];
            e_wd = w[7:0];
          end
        end else if (m_in) begin
          if (bus.i_Rx_DV) begin
            m_idle = 0;
            m_q.push_back(bus.i_Rx_Byte);
            m_eval();
          end else begin
            m_idle++;
            if (m_idle == T) begin
              m_err(ERR_TMO);
              m_in = 0;
            end
          end
        end else if (bus.i_Rx_DV &&
                     bus.i_Rx_Byte == 8'hA5) begin
          m_in = 1;
          m_q.delete();
          m_idle = 0;
        end
        e_busy = m_in || (m_busy > 0);
      end
    end
  end

  // ---------------- per-cycle compare + bus log
  logic [15:0] wlog[$];
  int rcnt = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("cycle",
          64'({bus.o_Wr_En,
               bus.o_Wr_En ? bus.o_Wr_Addr : 8'h0,
               bus.o_Wr_En ? bus.o_Wr_Data : 8'h0,
               bus.o_Rd_Req, bus.o_Rd_Addr,
               bus.o_Rd_Len, bus.o_Busy, bus.o_Err,
               bus.o_Err_Code, bus.o_Err_Cnt}),
          64'({e_wr,
               e_wr ? e_wa : 8'h0,
               e_wr ? e_wd : 8'h0,
               e_rd, e_ra, e_rl, e_busy, e_err,
               e_code, e_cnt}));
        if (bus.o_Wr_En)
          wlog.push_back({bus.o_Wr_Addr, bus.o_Wr_Data});
        if (bus.o_Rd_Req) rcnt++;
      end
    end
  end

  // ---------------- stimulus
  logic [7:0] pk[$];

  task automatic send(input logic [7:0] b);
    bus.i_Rx_Byte = b;
    bus.i_Rx_DV   = 1'b1;
    @(negedge clk);
    bus.i_Rx_DV   = 1'b0;
  endtask

  task automatic send_q();
    foreach (pk[i]) send(pk[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [63:0] outs();
    return 64'({bus.o_Wr_En, bus.o_Wr_Addr,
                bus.o_Wr_Data, bus.o_Rd_Req,
                bus.o_Rd_Addr, bus.o_Rd_Len,
                bus.o_Busy, bus.o_Err,
                bus.o_Err_Code, bus.o_Err_Cnt});
  endfunction

  initial begin
    bus.i_Rx_DV   = 1'b0;
    bus.i_Rx_Byte = 8'h00;
    #5 rst_n = 1'b0;
    idle(3);
    check("reset_outs", outs(), 64'h0);
    rst_n = 1'b1;
    idle(2);

    // basic write
    pk = '{8'hA5, 8'h01, 8'h10, 8'h02,
           8'h11, 8'h22, 8'h20};
    send_q(); idle(4);
    check("wr_count", 64'(wlog.size()), 64'd2);
    if (wlog.size() >= 2) begin
      check("wr0", 64'(wlog[0]), 64'h1011);
      check("wr1", 64'(wlog[1]), 64'h1122);
    end
    check("wr_errcnt", 64'(bus.o_Err_Cnt), 64'd0);

    // read
    pk = '{8'hA5, 8'h02, 8'h40, 8'h04, 8'h46};
    send_q(); idle(4);
    check("rd_count", 64'(rcnt), 64'd1);
    check("rd_addr", 64'(bus.o_Rd_Addr), 64'h40);
    check("rd_len", 64'(bus.o_Rd_Len), 64'h04);
    check("rd_nowr", 64'(wlog.size()), 64'd2);

    // bad checksum, then a good write
    pk = '{8'hA5, 8'h01, 8'h10, 8'h02,
           8'h11, 8'h22, 8'h21};
    send_q(); idle(4);
    check("csum_nowr", 64'(wlog.size()), 64'd2);
    check("csum_code", 64'(bus.o_Err_Code), 64'd1);
    check("csum_cnt", 64'(bus.o_Err_Cnt), 64'd1);
    pk = '{8'hA5, 8'h01, 8'h10, 8'h02,
           8'h11, 8'h22, 8'h20};
    send_q(); idle(4);
    check("rewr_count", 64'(wlog.size()), 64'd4);

    // format errors
    pk = '{8'hA5, 8'h07, 8'h10, 8'h02,
           8'h11, 8'h22, 8'h20};
    send_q(); idle(4);
    check("fmt_cmd_code", 64'(bus.o_Err_Code), 64'd0);
    check("fmt_cmd_cnt", 64'(bus.o_Err_Cnt), 64'd2);
    pk = '{8'hA5, 8'h01, 8'h10, 8'h09,
           8'h01, 8'h02, 8'h03};
    send_q(); idle(4);
    check("fmt_big_cnt", 64'(bus.o_Err_Cnt), 64'd3);
    pk = '{8'hA5, 8'h01, 8'h10, 8'h00, 8'h11};
    send_q(); idle(4);
    check("fmt_zero_cnt", 64'(bus.o_Err_Cnt), 64'd4);
    pk = '{8'hA5, 8'h02, 8'h40, 8'h00, 8'h42};
    send_q(); idle(4);
    check("fmt_rd0_cnt", 64'(bus.o_Err_Cnt), 64'd5);
    check("fmt_rd0_code", 64'(bus.o_Err_Code), 64'd0);
    check("fmt_nowr", 64'(wlog.size()), 64'd4);

    // timeout, then an address-wrapping write
    pk = '{8'hA5, 8'h01};
    send_q();
    check("tmo_busy_in", 64'(bus.o_Busy), 64'd1);
    idle(T + 5);
    check("tmo_code", 64'(bus.o_Err_Code), 64'd2);
    check("tmo_cnt", 64'(bus.o_Err_Cnt), 64'd6);
    check("tmo_busy", 64'(bus.o_Busy), 64'd0);
    pk = '{8'hA5, 8'h01, 8'hFF, 8'h02,
           8'h33, 8'h44, 8'h8B};
    send_q(); idle(4);
    check("wrap_count", 64'(wlog.size()), 64'd6);
    if (wlog.size() >= 6) begin
      check("wrap0", 64'(wlog[4]), 64'hFF33);
      check("wrap1", 64'(wlog[5]), 64'h0044);
    end

    // reset mid-packet
    pk = '{8'hA5, 8'h01, 8'h10};
    send_q();
    rst_n = 1'b0;
    #1 check("midrst_outs", outs(), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(5);
    check("midrst_nowr", 64'(wlog.size()), 64'd6);
    check("midrst_idle", 64'(bus.o_Busy), 64'd0);

    // overrun during commit; dropped SOF starts nothing
    pk = '{8'hA5, 8'h01, 8'h20, 8'h03,
           8'h01, 8'h02, 8'h03, 8'h22};
    send_q();
    send(8'hA5);
    idle(5);
    check("ovr_code", 64'(bus.o_Err_Code), 64'd3);
    check("ovr_cnt", 64'(bus.o_Err_Cnt), 64'd1);
    check("ovr_count", 64'(wlog.size()), 64'd9);
    if (wlog.size() >= 9) begin
      check("ovr0", 64'(wlog[6]), 64'h2001);
      check("ovr1", 64'(wlog[7]), 64'h2102);
      check("ovr2", 64'(wlog[8]), 64'h2203);
    end
    check("ovr_busy", 64'(bus.o_Busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
